poly_eval_stream: RTL and testbench

Streaming polynomial evaluator: the generator-side counterpart of the gradient-descent polynomial fitter. It holds up to six signed fixed-point coefficients a0..a5 and, on a start pulse, evaluates p(x) = a0 + a1·x + … + aD·x^D over a window of DATA_SIZE consecutive integer x positions beginning at a programmable shift. Each saturated 16-bit sample is emitted on a valid/ready stream. It sits downstream of the fitter, reconstructing the fitted curve sample-by-sample for comparison against the raw window.

---
 rtl/poly_eval_stream_if.sv | 23 ++
 rtl/poly_eval_stream.sv | 91 +++++++++
 tb/tb_poly_eval_stream.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/poly_eval_stream_if.sv
// poly_eval_stream_if: coefficient bus, window control and sample stream of poly_eval_stream.
interface poly_eval_stream_if;
  logic        coef_we;
  logic [2:0]  coef_idx;
  logic [31:0] coef_data;
  logic [15:0] shift;
  logic        start;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        done;
  logic        ovf;
  modport master (
    output coef_we, coef_idx, coef_data, shift, start, out_ready,
    input  busy, out_valid, out_data, out_last, done, ovf
  );
  modport slave (
    input  coef_we, coef_idx, coef_data, shift, start, out_ready,
    output busy, out_valid, out_data, out_last, done, ovf
  );
endinterface

// File: rtl/poly_eval_stream.sv
// poly_eval_stream: Horner evaluation of a Q16.16 polynomial over DATA_SIZE consecutive x, streamed as 16-bit samples.
// Optional POLY_EVAL_SAT_EN clamps samples to the 16-bit range instead of wrapping.
module poly_eval_stream #(
  parameter int DATA_SIZE = 50,
  parameter int DEGREE    = 5
) (
  input logic clk,
  input logic rst,
  poly_eval_stream_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EVAL, OUT} state_t;
  state_t state, state_nxt;
  logic signed [31:0] a [6];
  logic signed [31:0] w [6];
  logic signed [63:0] acc, prod_sat, acc_step;
  logic signed [80:0] prod;
  logic [16:0] x;
  logic [15:0] n, out_val;
  logic [2:0]  step, cidx;
  logic        ovf, done, prod_clamp, out_clamp, fire, last, accept;
`ifdef POLY_EVAL_SAT_EN
  logic signed [48:0] res;
`endif
  always_comb begin
    prod       = $signed({{17{acc[63]}}, acc}) * $signed({64'd0, x});
    prod_clamp = ~(&prod[80:63] | ~|prod[80:63]);
    prod_sat   = prod_clamp ? (prod[80] ? {1'b1, 63'd0} : {1'b0, {63{1'b1}}}) : prod[63:0];
    cidx       = 3'(DEGREE - 1) - step;
    acc_step   = prod_sat + {{32{w[cidx][31]}}, w[cidx]};
    // (acc + 2^15) >>> 16 is the integer part plus the first fraction bit
`ifdef POLY_EVAL_SAT_EN
    res        = {acc[63], acc[63:16]} + 49'(acc[15]);
    out_clamp  = ~(&res[48:15] | ~|res[48:15]);
    out_val    = out_clamp ? (res[48] ? 16'h8000 : 16'h7fff) : res[15:0];
`else
    out_clamp  = 1'b0;
    out_val    = acc[31:16] + 16'(acc[15]);
`endif
    accept     = state == IDLE && bus.start;
    fire       = state == OUT && bus.out_ready;
    last       = n == 16'(DATA_SIZE - 1);
    state_nxt  = state == IDLE ? (bus.start ? EVAL : IDLE) :
                 state == EVAL ? (step == 3'(DEGREE - 1) ? OUT : EVAL) :
                 fire ? (last ? IDLE : EVAL) : OUT;
    bus.busy      = state != IDLE;
    bus.out_valid = state == OUT;
    bus.out_data  = state == OUT ? out_val : 16'd0;
    bus.out_last  = state == OUT && last;
    bus.done      = done;
    bus.ovf       = ovf;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      for (int i = 0; i < 6; i++) begin
        a[i] <= '0;
        w[i] <= '0;
      end
      acc  <= '0;
      x    <= '0;
      n    <= '0;
      step <= '0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= fire && last;
      ovf   <= accept ? 1'b0 : ovf | (state == EVAL && prod_clamp) | (state == OUT && out_clamp);
      for (int i = 0; i < 6; i++)
        if (bus.coef_we && state == IDLE && bus.coef_idx == 3'(i)) a[i] <= bus.coef_data;
      // the window works from a snapshot so a same-cycle write only affects later windows
      if (accept) begin
        for (int i = 0; i < 6; i++) w[i] <= a[i];
        x    <= {1'b0, bus.shift};
        n    <= '0;
        step <= '0;
        acc  <= {{32{a[DEGREE][31]}}, a[DEGREE]};
      end
      if (state == EVAL) begin
        acc  <= acc_step;
        step <= step + 3'd1;
      end
      if (fire && !last) begin
        x    <= {1'b0, x[15:0] + 16'd1};
        n    <= n + 16'd1;
        step <= '0;
        acc  <= {{32{w[DEGREE][31]}}, w[DEGREE]};
      end
    end
  end
endmodule

// File: tb/tb_poly_eval_stream.sv
// tb_poly_eval_stream: directed vector table plus backpressure, coefficient-timing and mid-window reset sequences.
module tb_poly_eval_stream;
  localparam int DEGREE = 5;
  typedef struct packed {
    logic [5:0][31:0] coef;
    logic [15:0]      shift;
    logic [3:0][15:0] exp;
    logic             ovf;
  } vec_t;
  logic clk = 0;
  logic rst = 1;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t v [7];
  poly_eval_stream_if bus();
  poly_eval_stream #(.DATA_SIZE(4), .DEGREE(DEGREE)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic vec_t mk(logic [31:0] c0, c1, c2, c3, c4, c5, logic [15:0] sh,
                              logic [15:0] e0, e1, e2, e3, logic o);
    vec_t r;
    r.coef  = {c5, c4, c3, c2, c1, c0};
    r.shift = sh;
    r.exp   = {e3, e2, e1, e0};
    r.ovf   = o;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic write_coefs(input logic [5:0][31:0] c);
    for (int i = 0; i < 6; i++) begin
      bus.coef_we   = 1;
      bus.coef_idx  = 3'(i);
      bus.coef_data = c[i];
      @(negedge clk);
    end
    bus.coef_we = 0;
  endtask
  // starts a window at the current negedge and consumes all four samples
  task automatic run_window(input logic [15:0] sh, input logic [3:0][15:0] exp, input logic exp_ovf,
                            input int hold_at, input logic busy_wr);
    int cnt;
    bus.shift = sh;
    bus.start = 1;
    @(negedge clk);
    bus.start     = 0;
    bus.coef_we   = busy_wr;
    bus.coef_idx  = 0;
    bus.coef_data = 32'h022B0000;
    chk("busy_rise", 32'(bus.busy), 1);
    for (int s = 0; s < 4; s++) begin
      cnt = 0;
      while (!bus.out_valid && cnt < 40) begin
        @(negedge clk);
        bus.coef_we = 0;
        cnt++;
      end
      chk("latency", cnt, DEGREE);
      if (s == hold_at) begin
        bus.out_ready = 0;
        for (int k = 0; k < 3; k++) begin
          bus.start = (k == 1);
          @(negedge clk);
          chk("hold_valid", 32'(bus.out_valid), 1);
          chk("hold_data", 32'(bus.out_data), 32'(exp[s]));
          chk("hold_last", 32'(bus.out_last), 32'(s == 3));
        end
        bus.start     = 0;
        bus.out_ready = 1;
      end
      chk("sample", 32'(bus.out_data), 32'(exp[s]));
      chk("last", 32'(bus.out_last), 32'(s == 3));
      @(negedge clk);
    end
    chk("done", 32'(bus.done), 1);
    chk("busy_fall", 32'(bus.busy), 0);
    chk("ovf", 32'(bus.ovf), 32'(exp_ovf));
  endtask
  initial begin
    int cnt;
    bus.coef_we = 0; bus.coef_idx = 0; bus.coef_data = 0;
    bus.shift = 0; bus.start = 0; bus.out_ready = 1;
    v[0] = mk(32'h00640000, 0, 0, 0, 0, 0, 16'd0, 16'd100, 16'd100, 16'd100, 16'd100, 0);
    v[1] = mk(32'hFFFD0000, 32'h00020000, 0, 0, 0, 0, 16'd10, 16'd17, 16'd19, 16'd21, 16'd23, 0);
    v[2] = mk(0, 0, 32'h00008000, 0, 0, 0, 16'd3, 16'd5, 16'd8, 16'd13, 16'd18, 0);
    v[3] = mk(32'hFFFF8000, 0, 0, 0, 0, 0, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 0);
    v[5] = mk(32'h00010000, 32'hFFFE0000, 0, 0, 0, 0, 16'd100, 16'hFF39, 16'hFF37, 16'hFF35, 16'hFF33, 0);
`ifdef POLY_EVAL_SAT_EN
    v[4] = mk(0, 0, 0, 0, 0, 32'h00010000, 16'd10, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1);
    v[6] = mk(0, 32'h00010000, 0, 0, 0, 0, 16'd65534, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0001, 1);
`else
    v[4] = mk(0, 0, 0, 0, 0, 32'h00010000, 16'd10, 16'h86A0, 16'h751B, 16'hCC00, 16'hAA5D, 0);
    v[6] = mk(0, 32'h00010000, 0, 0, 0, 0, 16'd65534, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 0);
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data", 32'(bus.out_data), 0);
    chk("rst_last", 32'(bus.out_last), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      write_coefs(v[i].coef);
      run_window(v[i].shift, v[i].exp, v[i].ovf, i == 1 ? 1 : -1, 0);
    end
    // same-cycle write lands after the window snapshot; writes while busy are dropped
    write_coefs({160'd0, 32'h00640000});
    bus.coef_we = 1; bus.coef_idx = 0; bus.coef_data = 32'h00C80000;
    run_window(16'd0, {4{16'd100}}, 0, -1, 0);
    run_window(16'd0, {4{16'd200}}, 0, -1, 1);
    @(negedge clk);
    chk("done_pulse_end", 32'(bus.done), 0);
    run_window(16'd0, {4{16'd200}}, 0, -1, 0);
    // reset while the second sample is being evaluated
    write_coefs(v[1].coef);
    bus.shift = 10; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    cnt = 0;
    while (!bus.out_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("pre_rst_sample", 32'(bus.out_data), 17);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 1);
    rst = 1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_data", 32'(bus.out_data), 0);
    chk("mid_rst_last", 32'(bus.out_last), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_ovf", 32'(bus.ovf), 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    run_window(16'd10, {4{16'd0}}, 0, -1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
